// File: rtl/mul_pkg.sv
// Shared constants and types for the product accumulator stage that sits
// after serial_multiplier.
package mul_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int GROUP_MAX  = 255;
    localparam int CNT_W      = $clog2(GROUP_MAX + 1);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mul_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with carry-out.
// MUL_ACC_SATURATE_EN clamps the result to all-ones on carry instead of wrapping.
module mul_acc_add #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign carry = wide[ACC_W];

`ifdef MUL_ACC_SATURATE_EN
    // A clamped acc stays clamped: any further nonzero add carries again.
    assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul_product_accumulator.sv
// Sums each group of GROUP_N products and presents the group sum over valid/ready.
// Optional clamp-on-overflow behaviour is enabled by MUL_ACC_SATURATE_EN.
module mul_product_accumulator
    import mul_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int GROUP_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;

    mul_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc   (acc),
        .prod  (in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_W'(GROUP_N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (accept && last) state_nxt = HOLD;
            HOLD:    if (out_ready)      state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // clr only gates intake; it never touches a completed group in HOLD.
    always_comb begin
        in_ready  = (state == ACC) && !clr;
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (state == ACC) begin
            if (clr) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    out_sum <= add_sum;
                    out_ovf <= ovf | add_carry;
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                end else begin
                    acc <= add_sum;
                    cnt <= cnt + CNT_W'(1);
                    ovf <= ovf | add_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench: default-width instance for handshake/clear/reset, plus a
// 17-bit instance for the overflow cases (wrap or clamp per MUL_ACC_SATURATE_EN).
module tb_mul_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_prod = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_sum;
    logic        out_ovf;

    logic        w_clr = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [15:0] w_in_prod = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [16:0] w_out_sum;
    logic        w_out_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_product_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    mul_product_accumulator #(
        .PROD_W  (16),
        .ACC_W   (17),
        .GROUP_N (4)
    ) dut17 (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_prod   (w_in_prod),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_sum   (w_out_sum),
        .out_ovf   (w_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then offers one product for one edge.
    task automatic push(input logic [15:0] p);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push17(input logic [15:0] p);
        int n = 0;
        while (!w_in_ready && n < 50) begin
            tick();
            n++;
        end
        check("push17_ready", 32'(w_in_ready), 32'd1);
        w_in_valid = 1'b1;
        w_in_prod  = p;
        tick();
        w_in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] sat_exp;
`ifdef MUL_ACC_SATURATE_EN
        sat_exp = 32'd131071;
`else
        sat_exp = 32'd131068;
`endif

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);

        // Basic group: out_valid appears right after the 4th accept edge
        out_ready = 1'b1;
        push(16'd8160);
        push(16'd888);
        push(16'd288);
        check("basic_no_early_valid", 32'(out_valid), 32'd0);
        push(16'd301);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_sum", 32'(out_sum), 32'd9637);
        check("basic_ovf", 32'(out_ovf), 32'd0);
        check("basic_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("basic_valid_drop", 32'(out_valid), 32'd0);
        check("basic_in_ready_back", 32'(in_ready), 32'd1);

        // Output backpressure
        out_ready = 1'b0;
        push(16'd8160);
        push(16'd888);
        push(16'd288);
        push(16'd301);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_sum_stable", 32'(out_sum), 32'd9637);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_still_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Clear mid-group: the product offered with clr must be dropped
        push(16'd100);
        push(16'd200);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 16'd999;
        #1;
        check("clr_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_no_valid", 32'(out_valid), 32'd0);
        push(16'd1);
        push(16'd2);
        push(16'd3);
        check("clr_count_restart", 32'(out_valid), 32'd0);
        push(16'd4);
        check("clr_valid", 32'(out_valid), 32'd1);
        check("clr_sum", 32'(out_sum), 32'd10);
        check("clr_ovf", 32'(out_ovf), 32'd0);
        tick();

        // clr during HOLD must not lose the completed group
        out_ready = 1'b0;
        push(16'd7);
        push(16'd7);
        push(16'd7);
        push(16'd7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("hold_clr_valid", 32'(out_valid), 32'd1);
        check("hold_clr_sum", 32'(out_sum), 32'd28);

        // Reset in HOLD
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_sum", 32'(out_sum), 32'd0);
        check("hold_rst_in_ready", 32'(in_ready), 32'd1);
        check("hold_rst_ovf", 32'(out_ovf), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(16'd10);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_sum", 32'(out_sum), 32'd40);
        tick();

        // Overflow on the 17-bit instance: 4 x 65535
        for (int i = 0; i < 4; i++) push17(16'd65535);
        check("ovf_valid", 32'(w_out_valid), 32'd1);
        check("ovf_sum", 32'(w_out_sum), sat_exp);
        check("ovf_flag", 32'(w_out_ovf), 32'd1);
        tick();
        check("ovf_released", 32'(w_out_valid), 32'd0);

        // Sticky overflow must be cleared at group end
        for (int i = 0; i < 4; i++) push17(16'd1);
        check("ovf_next_sum", 32'(w_out_sum), 32'd4);
        check("ovf_next_flag", 32'(w_out_ovf), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
